// File: rtl/led_matrix_scan_pio.sv
// Avalon-MM LED matrix scanner with a double-buffered frame store.
// Software fills the back bank and requests a swap. The scan engine steps through
// the front bank one row at a time, and the banks swap only at a frame boundary.
module led_matrix_scan_pio #(
  parameter int ROWS        = 8,
  parameter int COLS        = 8,
  parameter int ADDR_W      = 4,
  parameter int DIV_W       = 16,
  parameter int DEFAULT_DIV = 49999
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              chipselect,
  input  logic              write_n,
  input  logic [31:0]       writedata,
  output logic [31:0]       readdata,
  output logic [ROWS-1:0]   row_out,
  output logic [COLS-1:0]   col_out,
  output logic              irq
);

  localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam logic [ADDR_W-1:0] A_CTRL = ADDR_W'(ROWS);
  localparam logic [ADDR_W-1:0] A_DIV  = ADDR_W'(ROWS + 1);
  localparam logic [ADDR_W-1:0] A_STAT = ADDR_W'(ROWS + 2);
  localparam logic [RW-1:0]     LAST_ROW = RW'(ROWS - 1);
  localparam logic [ROWS-1:0]   ROW_ONE  = {{(ROWS-1){1'b0}}, 1'b1};

  logic [COLS-1:0]  bank0 [ROWS];
  logic [COLS-1:0]  bank1 [ROWS];
  logic             en, row_al, irq_en, swap_pending, front_sel, frame_flag;
  logic [DIV_W-1:0] divider, prescaler;
  logic [RW-1:0]    row_idx;
  logic [RW-1:0]    a_idx;
  logic             wr, wr_row, wr_ctrl, wr_div, wr_stat;
  logic             tick, wrap, swap_now;
  logic [COLS-1:0]  front_row, back_row;
  logic             unused_wdata;

  assign wr      = chipselect & ~write_n;
  assign a_idx   = address[RW-1:0];
  assign wr_row  = wr && (address < A_CTRL);
  assign wr_ctrl = wr && (address == A_CTRL);
  assign wr_div  = wr && (address == A_DIV);
  assign wr_stat = wr && (address == A_STAT);
  assign unused_wdata = ^writedata;

  assign tick = en && (prescaler == divider);
  assign wrap = tick && (row_idx == LAST_ROW);
  // While scanning, a pending swap waits for the frame wrap. While idle, it applies at once.
  assign swap_now = swap_pending && (en ? wrap : 1'b1);

  assign front_row = front_sel ? bank1[row_idx] : bank0[row_idx];
  assign back_row  = front_sel ? bank0[a_idx] : bank1[a_idx];
  assign irq       = frame_flag & irq_en;

  // Control registers, prescaler, row counter, bank select and frame flag
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      en           <= 1'b0;
      row_al       <= 1'b0;
      irq_en       <= 1'b0;
      swap_pending <= 1'b0;
      front_sel    <= 1'b0;
      frame_flag   <= 1'b0;
      divider      <= DIV_W'(DEFAULT_DIV);
      prescaler    <= '0;
      row_idx      <= '0;
    end else begin
      if (wr_ctrl) begin
        en     <= writedata[0];
        row_al <= writedata[1];
        irq_en <= writedata[2];
      end
      if (swap_now) front_sel <= ~front_sel;
      // A new request in the consuming cycle survives until the next wrap
      if (wr_ctrl && writedata[3]) swap_pending <= 1'b1;
      else if (swap_now)           swap_pending <= 1'b0;
      if (wr_div) divider <= writedata[DIV_W-1:0];
      if (!en) begin
        prescaler <= '0;
        row_idx   <= '0;
      end else begin
        if (tick || wr_div) prescaler <= '0;
        else                prescaler <= prescaler + DIV_W'(1);
        if (tick) row_idx <= wrap ? '0 : row_idx + RW'(1);
      end
      // When a set and a clear arrive in the same cycle, the set takes priority.
      if (wrap)                         frame_flag <= 1'b1;
      else if (wr_stat && writedata[0]) frame_flag <= 1'b0;
    end
  end

  // Frame store: bus writes always target the bank that is not currently displayed
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < ROWS; i++) begin
        bank0[i] <= '0;
        bank1[i] <= '0;
      end
    end else if (wr_row) begin
      if (front_sel) bank0[a_idx] <= writedata[COLS-1:0];
      else           bank1[a_idx] <= writedata[COLS-1:0];
    end
  end

  // Registered matrix drive that follows row_idx and front_sel one cycle later
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_out <= '0;
      col_out <= '0;
    end else if (en) begin
      row_out <= (ROW_ONE << row_idx) ^ {ROWS{row_al}};
      col_out <= front_row;
    end else begin
      row_out <= {ROWS{row_al}};
      col_out <= '0;
    end
  end

  // Zero-latency read mux
  always_comb begin
    readdata = '0;
    if (address < A_CTRL) begin
      readdata = 32'(back_row);
    end else if (address == A_CTRL) begin
      readdata[3:0] = {swap_pending, irq_en, row_al, en};
    end else if (address == A_DIV) begin
      readdata = 32'(divider);
    end else if (address == A_STAT) begin
      readdata[0]    = frame_flag;
      readdata[1]    = front_sel;
      readdata[15:8] = 8'(row_idx);
    end
  end

endmodule
